dma_chan_sched: RTL and testbench
=================================

# dma_chan_sched

Multi-channel descriptor scheduler for the DMA controller: generalises the fixed two-direction host-to-FPGA/FPGA-to-host pairing to NUM_CHAN independent channels sharing one data mover. Each channel has a descriptor FIFO, per-channel fence ordering, an enable mask and a completion IRQ pulse. A round-robin arbiter issues descriptors to the mover. The block sits between the dispatcher CSR logic (submit side) and a dma_data_transfer-class mover (issue/complete side).

## Interface
- NUM_CHAN, 4: number of channels, 1..16.
- ADDR_WIDTH, 48: source/destination address width.
- LEN_WIDTH, 32: transfer length width in bytes.
- QDEPTH, 4: per-channel descriptor FIFO depth, power of 2, ≥2.
- MAX_OUT, 8: max descriptors in flight per channel at the mover.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high; all state cleared.
- chan_en  in  NUM_CHAN  channel enable mask; a disabled channel is not eligible for issue.
- desc_valid  in  NUM_CHAN  per-channel submit valid.
- desc_ready  out  NUM_CHAN  per-channel submit ready (= FIFO not full).
- desc_src  in  NUM_CHAN*ADDR_WIDTH  source address; channel c occupies slice [c*ADDR_WIDTH +: ADDR_WIDTH].
- desc_dst  in  NUM_CHAN*ADDR_WIDTH  destination address, same slicing.
- desc_len  in  NUM_CHAN*LEN_WIDTH  length, same slicing.
- desc_fence  in  NUM_CHAN  descriptor waits until all earlier descriptors of its channel have completed.
- mv_valid  out  1  issue valid to mover.
- mv_ready  in  1  mover accepts.
- mv_chan  out  $clog2(NUM_CHAN) (min 1)  issuing channel.
- mv_src, mv_dst  out  ADDR_WIDTH  addresses.
- mv_len  out  LEN_WIDTH  length.
- mv_done  in  1  completion strobe, one per issued descriptor.
- mv_done_chan  in  $clog2(NUM_CHAN)  channel of completion.
- irq_pulse  out  NUM_CHAN  one-cycle completion pulse per channel.
- chan_busy  out  NUM_CHAN  FIFO non-empty or outstanding ≠ 0.
- err_underflow  out  1  sticky: mv_done for a channel with outstanding = 0.

## Operation
- Submit: a descriptor is written into FIFO c when desc_valid[c] && desc_ready[c]. desc_ready[c] = (count[c] != QDEPTH), derived from registered count only.
- Eligibility of channel c: chan_en[c], FIFO non-empty, outstanding[c] < MAX_OUT, and (head fence = 0 or outstanding[c] = 0).
- Issue FSM: IDLE -> ISSUE when any channel is eligible; it grants the first eligible channel at or after rr_ptr, pops its head, and registers the mv_* fields. In ISSUE, mv_valid = 1 and all mv_* fields are held stable until mv_ready; on handshake it returns to IDLE, rr_ptr = granted+1 mod NUM_CHAN, and outstanding[granted] increments.
- Dropping chan_en while in ISSUE does not retract the issued descriptor.
- Completion: on mv_done with outstanding[mv_done_chan] > 0, decrement and pulse irq_pulse[mv_done_chan] on the next cycle. If outstanding = 0, set err_underflow and leave counters and IRQ unchanged.
- Same-cycle issue handshake and done on one channel: outstanding unchanged, IRQ still pulses.
- Same-cycle push and pop on one FIFO: count unchanged. A push to a full FIFO cannot occur.
- Arithmetic: FIFO pointers are $clog2(QDEPTH) bits and wrap naturally; count is $clog2(QDEPTH)+1 bits; outstanding is $clog2(MAX_OUT+1) bits; no saturation is needed given the guards.

## Timing
- Reset values: mv_valid 0, mv_* 0, irq_pulse 0, chan_busy 0, err_underflow 0, desc_ready all 1. FSM goes to IDLE, rr_ptr 0, and all FIFOs and counters are empty/0.
- Reset asserted mid-transfer: all queued and in-flight accounting is discarded immediately; there is no completion IRQ for lost work.
- Latency: accept at cycle T -> mv_valid at T+2 at the earliest, with the FIFO write at T and arbitration/register at T+1.
- Back-to-back issue: with mv_ready held high, one descriptor every 2 cycles (IDLE/ISSUE alternation).
- mv_done at T -> irq_pulse at T+1; outstanding is updated at T+1.
- chan_busy is registered from next-state count/outstanding.

## Test plan
- Single channel: submit src=0x1000, dst=0x2000, len=64 on ch0 with mv_ready=1 -> mv_valid at T+2 with mv_chan=0 and matching fields; mv_done -> irq_pulse[0] exactly one cycle, chan_busy[0] falls.
- Round-robin: fill ch0..ch3 with 2 descriptors each and hold mv_ready=1 -> issue order 0,1,2,3,0,1,2,3.
- Fence: on ch1, submit A (fence 0) then B (fence 1), no done -> only A issues; mv_done(1) -> B issues 2 cycles later.
- Backpressure/full: with QDEPTH=4 and chan_en[2]=0, push 4 to ch2 -> desc_ready[2]=0 and no issue; set chan_en[2]=1 -> 4 issues follow, and desc_ready[2] returns to 1 after the first pop. Hold mv_ready=0 for 5 cycles -> mv_* stable.
- MAX_OUT and errors: issue 8 on ch3 without done -> 9th held. mv_done for ch0 with outstanding 0 -> err_underflow=1 stays set, no irq.
- Async reset asserted while mv_valid=1 -> all outputs are at reset values before the next clk edge.

Source files
------------

// File: rtl/dma_chan_sched.sv
// Multi-channel DMA descriptor scheduler: per-channel descriptor FIFOs with fence
// ordering, round-robin issue to one shared data mover, per-channel completion IRQs.
module dma_chan_sched #(
  parameter  int NUM_CHAN   = 4,
  parameter  int ADDR_WIDTH = 48,
  parameter  int LEN_WIDTH  = 32,
  parameter  int QDEPTH     = 4,
  parameter  int MAX_OUT    = 8,
  localparam int CW         = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CHAN-1:0]            chan_en,
  input  logic [NUM_CHAN-1:0]            desc_valid,
  output logic [NUM_CHAN-1:0]            desc_ready,
  input  logic [NUM_CHAN*ADDR_WIDTH-1:0] desc_src,
  input  logic [NUM_CHAN*ADDR_WIDTH-1:0] desc_dst,
  input  logic [NUM_CHAN*LEN_WIDTH-1:0]  desc_len,
  input  logic [NUM_CHAN-1:0]            desc_fence,
  output logic                           mv_valid,
  input  logic                           mv_ready,
  output logic [CW-1:0]                  mv_chan,
  output logic [ADDR_WIDTH-1:0]          mv_src,
  output logic [ADDR_WIDTH-1:0]          mv_dst,
  output logic [LEN_WIDTH-1:0]           mv_len,
  input  logic                           mv_done,
  input  logic [CW-1:0]                  mv_done_chan,
  output logic [NUM_CHAN-1:0]            irq_pulse,
  output logic [NUM_CHAN-1:0]            chan_busy,
  output logic                           err_underflow
);

  localparam int PW  = $clog2(QDEPTH);
  localparam int QCW = PW + 1;
  localparam int OW  = $clog2(MAX_OUT + 1);
  localparam logic [QCW-1:0] FULL    = QCW'(QDEPTH);
  localparam logic [OW-1:0]  OUT_MAX = OW'(MAX_OUT);
  localparam logic [CW-1:0]  LAST    = CW'(NUM_CHAN - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [LEN_WIDTH-1:0]  len;
    logic                  fence;
  } desc_t;

  desc_t          mem       [NUM_CHAN][QDEPTH];
  logic [PW-1:0]  wr_ptr    [NUM_CHAN];
  logic [PW-1:0]  rd_ptr    [NUM_CHAN];
  logic [QCW-1:0] count     [NUM_CHAN];
  logic [QCW-1:0] count_nxt [NUM_CHAN];
  logic [OW-1:0]  outst     [NUM_CHAN];
  logic [OW-1:0]  outst_nxt [NUM_CHAN];

  state_t                state;
  logic [CW-1:0]         rr_ptr, grant, idx;
  logic                  any_elig, issue_hs, underflow;
  logic [NUM_CHAN-1:0]   push, pop, elig, done_hit, done_ok;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves a value held, which would infer a latch.
  always_comb begin
    desc_ready = '0;
    push       = '0;
    elig       = '0;
    done_hit   = '0;
    done_ok    = '0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      desc_ready[c] = (count[c] != FULL);
      push[c]       = desc_valid[c] && desc_ready[c];
      // A fenced head waits for the channel to drain completely.
      elig[c]       = chan_en[c] && (count[c] != '0) && (outst[c] < OUT_MAX) &&
                      (!mem[c][rd_ptr[c]].fence || (outst[c] == '0));
      done_hit[c]   = mv_done && (mv_done_chan == CW'(c));
      done_ok[c]    = done_hit[c] && (outst[c] != '0);
    end
  end

  // First eligible channel at or after rr_ptr.
  always_comb begin
    any_elig = 1'b0;
    grant    = '0;
    idx      = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      idx = CW'((int'(rr_ptr) + i) % NUM_CHAN);
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        grant    = idx;
      end
    end
  end

  always_comb begin
    issue_hs  = (state == ISSUE) && mv_ready;
    underflow = mv_done && !(|done_ok);
    pop       = '0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      pop[c]       = (state == IDLE) && any_elig && (grant == CW'(c));
      count_nxt[c] = count[c] + QCW'(push[c]) - QCW'(pop[c]);
      outst_nxt[c] = outst[c] + OW'(issue_hs && (mv_chan == CW'(c))) - OW'(done_ok[c]);
    end
  end

  // NOTE: descriptor storage has no reset; the reset pointers and counts alone
  // decide which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= '{src:   desc_src[c*ADDR_WIDTH +: ADDR_WIDTH],
                               dst:   desc_dst[c*ADDR_WIDTH +: ADDR_WIDTH],
                               len:   desc_len[c*LEN_WIDTH +: LEN_WIDTH],
                               fence: desc_fence[c]};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      mv_valid      <= 1'b0;
      mv_chan       <= '0;
      mv_src        <= '0;
      mv_dst        <= '0;
      mv_len        <= '0;
      irq_pulse     <= '0;
      chan_busy     <= '0;
      err_underflow <= 1'b0;
      for (int c = 0; c < NUM_CHAN; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
        outst[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
        count[c]     <= count_nxt[c];
        outst[c]     <= outst_nxt[c];
        chan_busy[c] <= (count_nxt[c] != '0) || (outst_nxt[c] != '0);
      end
      irq_pulse <= done_ok;
      if (underflow) err_underflow <= 1'b1;

      case (state)
        IDLE: if (any_elig) begin
          state    <= ISSUE;
          mv_valid <= 1'b1;
          mv_chan  <= grant;
          mv_src   <= mem[grant][rd_ptr[grant]].src;
          mv_dst   <= mem[grant][rd_ptr[grant]].dst;
          mv_len   <= mem[grant][rd_ptr[grant]].len;
        end
        ISSUE: if (mv_ready) begin
          state    <= IDLE;
          mv_valid <= 1'b0;
          rr_ptr   <= (mv_chan == LAST) ? '0 : mv_chan + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_chan_sched.sv
// Self-checking bench for dma_chan_sched: directed vector table, corner-case
// sequences, then randomized traffic against a queue-based reference model.
module tb_dma_chan_sched;

  localparam int NC = 4;
  localparam int AW = 48;
  localparam int LW = 32;
  localparam int QD = 4;
  localparam int MO = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [NC-1:0]  chan_en, desc_valid, desc_ready, desc_fence, irq_pulse, chan_busy;
  logic [NC*AW-1:0] desc_src, desc_dst;
  logic [NC*LW-1:0] desc_len;
  logic           mv_valid, mv_ready, mv_done, err_underflow;
  logic [1:0]     mv_chan, mv_done_chan;
  logic [AW-1:0]  mv_src, mv_dst;
  logic [LW-1:0]  mv_len;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dma_chan_sched #(.NUM_CHAN(NC), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .QDEPTH(QD), .MAX_OUT(MO)) dut (
    .clk(clk), .reset(reset), .chan_en(chan_en), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len), .desc_fence(desc_fence),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_chan(mv_chan), .mv_src(mv_src), .mv_dst(mv_dst),
    .mv_len(mv_len), .mv_done(mv_done), .mv_done_chan(mv_done_chan), .irq_pulse(irq_pulse),
    .chan_busy(chan_busy), .err_underflow(err_underflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] en, vld, fen;
    logic [AW-1:0] src, dst;
    logic [LW-1:0] len;
    logic rdy, done;
    logic [1:0] dch;
    logic e_valid;
    logic [1:0] e_chan;
    logic [AW-1:0] e_src, e_dst;
    logic [LW-1:0] e_len;
    logic [3:0] e_irq, e_busy;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] en, vld, fen, input logic [AW-1:0] src, dst,
                              input logic [LW-1:0] len, input logic rdy, done, input logic [1:0] dch,
                              input logic e_valid, input logic [1:0] e_chan,
                              input logic [AW-1:0] e_src, e_dst, input logic [LW-1:0] e_len,
                              input logic [3:0] e_irq, e_busy);
    vec_t v;
    v.en = en; v.vld = vld; v.fen = fen; v.src = src; v.dst = dst; v.len = len;
    v.rdy = rdy; v.done = done; v.dch = dch; v.e_valid = e_valid; v.e_chan = e_chan;
    v.e_src = e_src; v.e_dst = e_dst; v.e_len = e_len; v.e_irq = e_irq; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic idle_inputs();
    desc_valid   = '0;
    desc_fence   = '0;
    mv_done      = 1'b0;
    mv_done_chan = '0;
  endtask

  task automatic set_desc(input int c, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] l);
    desc_src[c*AW +: AW] = s;
    desc_dst[c*AW +: AW] = d;
    desc_len[c*LW +: LW] = l;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    chan_en  = '0;
    mv_ready = 1'b0;
    desc_src = '0;
    desc_dst = '0;
    desc_len = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: per-channel queues plus transaction-level bookkeeping.
  typedef struct packed {
    logic [AW-1:0] src, dst;
    logic [LW-1:0] len;
    logic fence;
  } desc_t;

  desc_t      m_q [NC][$];
  int         m_out [NC];
  int         m_rr, m_cur_chan;
  bit         m_issuing, m_err;
  desc_t      m_cur;
  logic [3:0] m_irq;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_q[i].delete();
      m_out[i] = 0;
    end
    m_rr = 0; m_cur_chan = 0; m_issuing = 0; m_err = 0; m_irq = '0; m_cur = '0;
  endtask

  task automatic model_step();
    int o_pre [NC];
    bit r_pre [NC];
    int g, c;
    for (int i = 0; i < NC; i++) begin
      o_pre[i] = m_out[i];
      r_pre[i] = (m_q[i].size() != QD);
    end
    m_irq = '0;
    if (!m_issuing) begin
      g = -1;
      for (int i = 0; i < NC; i++) begin
        c = (m_rr + i) % NC;
        if (g < 0 && chan_en[c] && m_q[c].size() > 0 && o_pre[c] < MO &&
            (!m_q[c][0].fence || o_pre[c] == 0)) g = c;
      end
      if (g >= 0) begin
        m_cur      = m_q[g].pop_front();
        m_cur_chan = g;
        m_issuing  = 1;
      end
    end else if (mv_ready) begin
      m_out[m_cur_chan]++;
      m_rr      = (m_cur_chan + 1) % NC;
      m_issuing = 0;
    end
    if (mv_done) begin
      if (o_pre[mv_done_chan] > 0) begin
        m_out[mv_done_chan]--;
        m_irq[mv_done_chan] = 1'b1;
      end else begin
        m_err = 1;
      end
    end
    for (int i = 0; i < NC; i++)
      if (desc_valid[i] && r_pre[i])
        m_q[i].push_back('{src: desc_src[i*AW +: AW], dst: desc_dst[i*AW +: AW],
                           len: desc_len[i*LW +: LW], fence: desc_fence[i]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int n_hs, pushed, found;
    logic [3:0] exp_busy, exp_ready;
    int cand[$];

    reset = 1'b1;
    do_reset();

    // Reset state
    check("rst_mv_valid", mv_valid, 0);
    check("rst_mv_chan", mv_chan, 0);
    check("rst_mv_src", mv_src, 0);
    check("rst_mv_dst", mv_dst, 0);
    check("rst_mv_len", mv_len, 0);
    check("rst_irq", irq_pulse, 0);
    check("rst_busy", chan_busy, 0);
    check("rst_err", err_underflow, 0);
    check("rst_ready", desc_ready, 4'hF);

    // Single transfer on ch0, then fence ordering on ch1.
    tbl.push_back(mk(4'hF, 4'h1, 4'h0, 48'h1000, 48'h2000, 32'h40, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h1));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 1, 0, 48'h1000, 48'h2000, 32'h40, 4'h0, 4'h0));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h1));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'h1, 4'h0));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(mk(4'hF, 4'h2, 4'h0, 48'hA0, 48'h1A0, 32'h8, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h2));
    tbl.push_back(mk(4'hF, 4'h2, 4'h2, 48'hB0, 48'h1B0, 32'h10, 1, 0, 0, 1, 1, 48'hA0, 48'h1A0, 32'h8, 4'h0, 4'h2));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h2));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h2));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h2));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 4'h2, 4'h2));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 1, 1, 48'hB0, 48'h1B0, 32'h10, 4'h0, 4'h0));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 1, 48'hB0, 48'h1B0, 32'h10, 4'h0, 4'h0));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h2));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 4'h2, 4'h0));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      chan_en = tbl[i].en; desc_valid = tbl[i].vld; desc_fence = tbl[i].fen;
      desc_src = {NC{tbl[i].src}}; desc_dst = {NC{tbl[i].dst}}; desc_len = {NC{tbl[i].len}};
      mv_ready = tbl[i].rdy; mv_done = tbl[i].done; mv_done_chan = tbl[i].dch;
      @(negedge clk);
      check($sformatf("tbl%0d_valid", i), mv_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        check($sformatf("tbl%0d_chan", i), mv_chan, tbl[i].e_chan);
        check($sformatf("tbl%0d_src", i), mv_src, tbl[i].e_src);
        check($sformatf("tbl%0d_dst", i), mv_dst, tbl[i].e_dst);
        check($sformatf("tbl%0d_len", i), mv_len, tbl[i].e_len);
      end
      check($sformatf("tbl%0d_irq", i), irq_pulse, tbl[i].e_irq);
      check($sformatf("tbl%0d_busy", i), chan_busy, tbl[i].e_busy);
      check($sformatf("tbl%0d_ready", i), desc_ready, 4'hF);
      check($sformatf("tbl%0d_err", i), err_underflow, 0);
    end
    idle_inputs();

    // Round robin: two descriptors on every channel, mover always ready.
    do_reset();
    chan_en = 4'hF; mv_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NC; c++) set_desc(c, AW'(48'h1000 * (c + 1) + k), AW'(48'h9000 + c), LW'(k + 1));
      desc_valid = 4'hF;
      @(negedge clk);
    end
    idle_inputs();
    n_hs = 0;
    for (int cyc = 0; cyc < 40 && n_hs < 8; cyc++) begin
      if (mv_valid) begin
        check($sformatf("rr%0d_chan", n_hs), mv_chan, n_hs % NC);
        check($sformatf("rr%0d_src", n_hs), mv_src, 48'h1000 * ((n_hs % NC) + 1) + n_hs / NC);
        n_hs++;
      end
      @(negedge clk);
    end
    check("rr_issue_count", n_hs, 8);

    // Full FIFO on a disabled channel, then enable and hold backpressure.
    do_reset();
    chan_en = 4'b1011; mv_ready = 1'b0;
    for (int k = 0; k < QD; k++) begin
      set_desc(2, AW'(48'h2200 + k), AW'(48'h3300 + k), LW'(32'h10 + k));
      desc_valid = 4'b0100;
      @(negedge clk);
    end
    idle_inputs();
    check("full_ready2", desc_ready[2], 0);
    check("disabled_no_issue", mv_valid, 0);
    @(negedge clk);
    check("disabled_no_issue2", mv_valid, 0);
    chan_en = 4'hF;
    @(negedge clk);
    check("enable_issue_valid", mv_valid, 1);
    check("enable_issue_chan", mv_chan, 2);
    check("ready2_after_pop", desc_ready[2], 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", mv_valid, 1);
      check("stall_src", mv_src, 48'h2200);
      check("stall_dst", mv_dst, 48'h3300);
      check("stall_len", mv_len, 32'h10);
    end
    mv_ready = 1'b1;
    n_hs = 0;
    for (int cyc = 0; cyc < 30 && n_hs < 4; cyc++) begin
      if (mv_valid) begin
        check($sformatf("bp%0d_src", n_hs), mv_src, 48'h2200 + n_hs);
        n_hs++;
      end
      @(negedge clk);
    end
    check("bp_issue_count", n_hs, 4);

    // MAX_OUT: nine descriptors on ch3 with no completions.
    do_reset();
    chan_en = 4'hF; mv_ready = 1'b1;
    pushed = 0; n_hs = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      desc_valid = '0;
      if (mv_valid) n_hs++;
      if (pushed < 9 && desc_ready[3]) begin
        set_desc(3, AW'(48'h300 + pushed), AW'(48'h700 + pushed), LW'(pushed + 1));
        desc_valid = 4'b1000;
        pushed++;
      end
      @(negedge clk);
    end
    idle_inputs();
    check("maxout_pushed", pushed, 9);
    check("maxout_issued", n_hs, 8);
    check("maxout_ninth_held", mv_valid, 0);
    check("maxout_busy3", chan_busy[3], 1);
    mv_done = 1'b1; mv_done_chan = 2'd3;
    @(negedge clk);
    idle_inputs();
    check("maxout_irq", irq_pulse, 4'b1000);
    found = 0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      if (mv_valid) found = 1;
      else @(negedge clk);
    end
    check("ninth_issued", found, 1);
    check("ninth_src", mv_src, 48'h308);

    // Completion on a channel with nothing outstanding.
    mv_done = 1'b1; mv_done_chan = 2'd0;
    @(negedge clk);
    idle_inputs();
    check("underflow_set", err_underflow, 1);
    check("underflow_no_irq", irq_pulse, 0);
    repeat (3) @(negedge clk);
    check("underflow_sticky", err_underflow, 1);

    // Asynchronous reset while a descriptor is being offered.
    do_reset();
    chan_en = 4'hF; mv_ready = 1'b0;
    set_desc(1, 48'hABC, 48'hDEF, 32'h99);
    desc_valid = 4'b0010;
    @(negedge clk);
    set_desc(1, 48'hABD, 48'hDF0, 32'h9A);
    @(negedge clk);
    idle_inputs();
    check("pre_reset_valid", mv_valid, 1);
    check("pre_reset_busy", chan_busy, 4'b0010);
    #2 reset = 1'b1;
    #1;
    check("async_mv_valid", mv_valid, 0);
    check("async_mv_src", mv_src, 0);
    check("async_mv_len", mv_len, 0);
    check("async_irq", irq_pulse, 0);
    check("async_busy", chan_busy, 0);
    check("async_err", err_underflow, 0);
    check("async_ready", desc_ready, 4'hF);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      check("rnd_valid", mv_valid, m_issuing);
      if (m_issuing) begin
        check("rnd_chan", mv_chan, m_cur_chan);
        check("rnd_src", mv_src, m_cur.src);
        check("rnd_dst", mv_dst, m_cur.dst);
        check("rnd_len", mv_len, m_cur.len);
      end
      exp_busy = '0; exp_ready = '0;
      for (int c = 0; c < NC; c++) begin
        exp_busy[c]  = (m_q[c].size() != 0) || (m_out[c] != 0);
        exp_ready[c] = (m_q[c].size() != QD);
      end
      check("rnd_irq", irq_pulse, m_irq);
      check("rnd_busy", chan_busy, exp_busy);
      check("rnd_ready", desc_ready, exp_ready);
      check("rnd_err", err_underflow, m_err);

      for (int c = 0; c < NC; c++) begin
        chan_en[c] = ($urandom_range(0, 9) != 0);
        set_desc(c, AW'({$urandom(), $urandom()}), AW'({$urandom(), $urandom()}), LW'($urandom()));
      end
      desc_valid = 4'($urandom());
      desc_fence = 4'($urandom() & $urandom());
      mv_ready   = ($urandom_range(0, 3) != 0);
      cand.delete();
      for (int c = 0; c < NC; c++) if (m_out[c] > 0) cand.push_back(c);
      mv_done = 1'b0; mv_done_chan = '0;
      if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        mv_done      = 1'b1;
        mv_done_chan = 2'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      model_step();
      @(negedge clk);
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
